// File: rtl/sha_msg_padder.sv
// sha_msg_padder: FIPS 180-4 message padder feeding SHA-256/384/512 blocks to the scheduler.
// Optional 1024-bit block support is enabled by defining SHA_PAD_SHA512_EN.
module sha_msg_padder #(
   parameter int LEN_W = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    hash_size,
   input  logic [31:0]   din,
   input  logic          din_valid,
   output logic          din_ready,
   input  logic          din_last,
   input  logic [1:0]    din_bytes,
   output logic [1023:0] blk_out,
   output logic          blk_valid,
   output logic          blk_last,
   input  logic          blk_ack
);
`ifdef SHA_PAD_SHA512_EN
   localparam int NW = 32;
`else
   localparam int NW = 16;
`endif
   localparam int AW = $clog2(NW);
   typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, OUT} state_t;
   state_t r_state, w_state_nx;
   logic [5:0] r_wcnt, w_wcnt_nx, w_wc, w_bw, w_lw, w_add;
   logic [1:0] w_lsel;
   logic [LEN_W-1:0] r_len, w_len_nx, w_lbase, w_len_sum;
   logic r_extra, w_extra_nx, r_need80, w_need80_nx, r_last, w_last_nx;
   logic w_s512, w_hs, w_we, w_clr, w_unused;
   logic [AW-1:0] w_widx;
   logic [31:0] w_wdata, w_din_m;
   logic [127:0] w_len_ext;
   logic [31:0] r_mem [NW];
`ifdef SHA_PAD_SHA512_EN
   logic r_sha512;
   assign w_s512 = (r_state == IDLE) ? hash_size[1] : r_sha512;
`else
   assign w_s512 = 1'b0;
`endif
   assign w_unused  = ^hash_size;
   assign w_bw      = w_s512 ? 6'd32 : 6'd16;
   assign w_lw      = w_s512 ? 6'd4 : 6'd2;
   assign w_wc      = (r_state == IDLE) ? 6'd0 : r_wcnt;
   assign w_lbase   = (r_state == IDLE) ? '0 : r_len;
   assign w_add     = (din_last && din_bytes != 2'd0) ? {1'b0, din_bytes, 3'b000} : 6'd32;
   assign w_len_sum = w_lbase + LEN_W'(w_add);
   assign w_len_ext = 128'(r_len);
   assign w_lsel    = 2'(w_bw - 6'd1 - r_wcnt);
   assign w_hs      = din_valid & din_ready;
   assign din_ready = ~rst & (r_state == IDLE || r_state == FILL);
   assign blk_valid = (r_state == OUT);
   assign blk_last  = r_last;
   // the 0x80 terminator replaces the first invalid byte of a partial last word
   assign w_din_m = (!din_last || din_bytes == 2'd0) ? din :
                    (din_bytes == 2'd1) ? {din[31:24], 24'h800000} :
                    (din_bytes == 2'd2) ? {din[31:16], 16'h8000} : {din[31:8], 8'h80};
   always_comb begin
      w_state_nx  = r_state;
      w_wcnt_nx   = r_wcnt;
      w_len_nx    = r_len;
      w_extra_nx  = r_extra;
      w_need80_nx = r_need80;
      w_last_nx   = r_last;
      w_we        = 1'b0;
      w_clr       = 1'b0;
      w_widx      = r_wcnt[AW-1:0];
      w_wdata     = w_din_m;
      case (r_state)
         IDLE, FILL: if (w_hs) begin
            w_we        = 1'b1;
            w_widx      = w_wc[AW-1:0];
            w_wcnt_nx   = w_wc + 6'd1;
            w_len_nx    = w_len_sum;
            w_need80_nx = din_last & (din_bytes == 2'd0);
            w_extra_nx  = 1'b0;
            w_last_nx   = 1'b0;
            w_state_nx  = din_last ? PAD : (w_wc + 6'd1 == w_bw) ? OUT : FILL;
         end
         // a terminator at or past the length field never meets BW-LW, so it spills into an extra block
         PAD: if (r_wcnt == w_bw) begin
            w_state_nx = OUT;
            w_extra_nx = 1'b1;
         end else if (r_need80) begin
            w_we        = 1'b1;
            w_wdata     = 32'h8000_0000;
            w_wcnt_nx   = r_wcnt + 6'd1;
            w_need80_nx = 1'b0;
         end else if (r_wcnt == w_bw - w_lw) begin
            w_state_nx = LEN;
         end else begin
            w_wcnt_nx = r_wcnt + 6'd1;
         end
         LEN: begin
            w_we      = 1'b1;
            w_wdata   = w_len_ext[{w_lsel, 5'd0} +: 32];
            w_wcnt_nx = r_wcnt + 6'd1;
            if (r_wcnt == w_bw - 6'd1) begin
               w_state_nx = OUT;
               w_last_nx  = 1'b1;
            end
         end
         OUT: if (blk_ack) begin
            w_clr      = 1'b1;
            w_wcnt_nx  = 6'd0;
            w_last_nx  = 1'b0;
            w_extra_nx = 1'b0;
            w_state_nx = r_last ? IDLE : r_extra ? PAD : FILL;
         end
         default: w_state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_wcnt   <= '0;
         r_len    <= '0;
         r_extra  <= 1'b0;
         r_need80 <= 1'b0;
         r_last   <= 1'b0;
`ifdef SHA_PAD_SHA512_EN
         r_sha512 <= 1'b0;
`endif
         for (int i = 0; i < NW; i++) r_mem[i] <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_wcnt   <= w_wcnt_nx;
         r_len    <= w_len_nx;
         r_extra  <= w_extra_nx;
         r_need80 <= w_need80_nx;
         r_last   <= w_last_nx;
`ifdef SHA_PAD_SHA512_EN
         if (w_hs && r_state == IDLE) r_sha512 <= w_s512;
`endif
         if (w_clr) for (int i = 0; i < NW; i++) r_mem[i] <= '0;
         else if (w_we) r_mem[w_widx] <= w_wdata;
      end
   end
   always_comb begin
      blk_out = '0;
`ifdef SHA_PAD_SHA512_EN
      if (r_sha512) for (int i = 0; i < 32; i++) blk_out[1023-32*i -: 32] = r_mem[i];
      else for (int i = 0; i < 16; i++) blk_out[1023-64*i -: 64] = {32'h0, r_mem[i]};
`else
      for (int i = 0; i < 16; i++) blk_out[1023-64*i -: 64] = {32'h0, r_mem[i]};
`endif
   end
endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: directed vectors for sha_msg_padder with hand-computed padded blocks.
module tb_sha_msg_padder;
   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    hash_size;
   logic [31:0]   din;
   logic          din_valid;
   logic          din_ready;
   logic          din_last;
   logic [1:0]    din_bytes;
   logic [1023:0] blk_out;
   logic          blk_valid;
   logic          blk_last;
   logic          blk_ack;
   int vectors = 0;
   int miscompares = 0;
   int n;
   logic [31:0] ew [32];
   logic [1023:0] exp_blk;

   sha_msg_padder dut (
      .clk(clk), .rst(rst), .hash_size(hash_size), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .din_last(din_last), .din_bytes(din_bytes), .blk_out(blk_out),
      .blk_valid(blk_valid), .blk_last(blk_last), .blk_ack(blk_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] expv);
      int k = 0;
      vectors++;
      for (int i = 0; i < 32; i++) if (got[32*i +: 32] !== expv[32*i +: 32]) k = 31 - i;
      assert (got === expv) else begin
         miscompares++;
         $error("FAIL %s word%0d got=%h exp=%h", tag, k, got[1023-32*k -: 32], expv[1023-32*k -: 32]);
      end
   endtask

   task automatic chkb(input string tag, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      assert (got === expv) else begin
         miscompares++;
         $error("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   task automatic clr_ew();
      for (int i = 0; i < 32; i++) ew[i] = 32'h0;
   endtask

   function automatic logic [1023:0] mk(input bit s512);
      logic [1023:0] r = '0;
      for (int i = 0; i < 32; i++)
         if (s512) r[1023-32*i -: 32] = ew[i];
         else if (i < 16) r[1023-64*i -: 64] = {32'h0, ew[i]};
      return r;
   endfunction

   task automatic send(input logic [31:0] w, input logic l, input logic [1:0] b);
      int k = 0;
      din = w; din_last = l; din_bytes = b; din_valid = 1'b1;
      while (!din_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chkb("send_ready", {31'b0, din_ready}, 1);
      @(posedge clk); #1;
      din_valid = 1'b0; din_last = 1'b0; din_bytes = 2'd0;
   endtask

   task automatic wait_blk(output int cyc);
      cyc = 0;
      while (!blk_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chkb("blk_valid_timeout", {31'b0, blk_valid}, 1);
   endtask

   task automatic ack();
      blk_ack = 1'b1;
      @(posedge clk); #1;
      blk_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; hash_size = 2'd0; din = '0; din_valid = 1'b0; din_last = 1'b0;
      din_bytes = 2'd0; blk_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chkb("rst_din_ready", {31'b0, din_ready}, 0);
      chkb("rst_blk_valid", {31'b0, blk_valid}, 0);
      chkb("rst_blk_last", {31'b0, blk_last}, 0);
      chk("rst_blk_out", blk_out, '0);
      rst = 1'b0; #1;
      chkb("idle_din_ready", {31'b0, din_ready}, 1);
      ack();
      chkb("idle_ack_valid", {31'b0, blk_valid}, 0);
      chkb("idle_ack_ready", {31'b0, din_ready}, 1);

      send(32'h61626300, 1'b1, 2'd3);
      wait_blk(n);
      chkb("abc256_latency_ok", {31'b0, n <= 17}, 1);
      clr_ew(); ew[0] = 32'h61626380; ew[15] = 32'h18;
      chk("abc256_blk", blk_out, mk(0));
      chkb("abc256_last", {31'b0, blk_last}, 1);
      chkb("abc256_out_ready", {31'b0, din_ready}, 0);
      ack();
      chkb("abc256_ack_valid", {31'b0, blk_valid}, 0);
      chkb("abc256_ack_ready", {31'b0, din_ready}, 1);

      hash_size = 2'b10;
      send(32'h61626300, 1'b1, 2'd3);
      hash_size = 2'b00;
      wait_blk(n);
      clr_ew(); ew[0] = 32'h61626380;
`ifdef SHA_PAD_SHA512_EN
      ew[31] = 32'h18;
      exp_blk = mk(1);
      chkb("abc512_hi", blk_out[1023:992], 32'h61626380);
      chkb("abc512_lo", blk_out[31:0], 32'h18);
      chkb("abc512_latency_ok", {31'b0, n <= 33}, 1);
`else
      ew[15] = 32'h18;
      exp_blk = mk(0);
`endif
      chk("abc512_blk", blk_out, exp_blk);
      chkb("abc512_last", {31'b0, blk_last}, 1);
      ack();

      for (int i = 0; i < 14; i++) send(32'h1000_0000 + i, i == 13, 2'd0);
      wait_blk(n);
      clr_ew();
      for (int i = 0; i < 14; i++) ew[i] = 32'h1000_0000 + i;
      ew[14] = 32'h8000_0000;
      chk("m56_blk1", blk_out, mk(0));
      chkb("m56_blk1_last", {31'b0, blk_last}, 0);
      ack();
      wait_blk(n);
      clr_ew(); ew[15] = 32'h1C0;
      chk("m56_blk2", blk_out, mk(0));
      chkb("m56_blk2_last", {31'b0, blk_last}, 1);
      ack();

      for (int i = 0; i < 13; i++) send(32'h2000_0000 + i, 1'b0, 2'd0);
      send(32'h0D0D0DFF, 1'b1, 2'd3);
      wait_blk(n);
      clr_ew();
      for (int i = 0; i < 13; i++) ew[i] = 32'h2000_0000 + i;
      ew[13] = 32'h0D0D0D80; ew[15] = 32'h1B8;
      chk("m55_blk", blk_out, mk(0));
      chkb("m55_last", {31'b0, blk_last}, 1);
      ack();

      for (int i = 0; i < 16; i++) send(32'h3000_0000 + i, 1'b0, 2'd0);
      wait_blk(n);
      clr_ew();
      for (int i = 0; i < 16; i++) ew[i] = 32'h3000_0000 + i;
      exp_blk = mk(0);
      chk("bp_blk1", blk_out, exp_blk);
      chkb("bp_blk1_last", {31'b0, blk_last}, 0);
      din = 32'hAABBCCDD; din_last = 1'b1; din_bytes = 2'd1; din_valid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         chkb("bp_hold_ready", {31'b0, din_ready}, 0);
         chk("bp_hold_stable", blk_out, exp_blk);
      end
      ack();
      send(32'hAABBCCDD, 1'b1, 2'd1);
      wait_blk(n);
      clr_ew(); ew[0] = 32'hAA800000; ew[15] = 32'h208;
      chk("bp_blk2", blk_out, mk(0));
      chkb("bp_blk2_last", {31'b0, blk_last}, 1);
      ack();

      for (int i = 0; i < 5; i++) send(32'h4000_0000 + i, 1'b0, 2'd0);
      rst = 1'b1; #1;
      chkb("rstmid_ready", {31'b0, din_ready}, 0);
      chkb("rstmid_valid", {31'b0, blk_valid}, 0);
      @(posedge clk); #1;
      chkb("rstmid_ready_hold", {31'b0, din_ready}, 0);
      rst = 1'b0; #1;
      send(32'h61626300, 1'b1, 2'd3);
      wait_blk(n);
      clr_ew(); ew[0] = 32'h61626380; ew[15] = 32'h18;
      chk("rstmid_abc_blk", blk_out, mk(0));
      chkb("rstmid_abc_last", {31'b0, blk_last}, 1);
      ack();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sha_msg_padder.md
Name: sha_msg_padder

Overview:
- Upstream feeder of the SHA message scheduler.
- Accepts a big-endian 32-bit byte stream with valid/ready handshaking.
- Applies FIPS 180-4 padding and appends the message bit length.
- Presents each complete 512-bit (SHA-256) or 1024-bit (SHA-384/512) block on the 1024-bit block bus. The scheduler loads that bus with start/input_valid.

Parameters:
- LEN_W, 64, width of the message bit-length counter. SHA-512 length-field bits above LEN_W are zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- hash_size  in  2  bit1=1 selects SHA-384/512 (1024-bit block), 0 selects SHA-256. Sampled only in IDLE.
- din  in  32  message word; first byte in din[31:24]
- din_valid  in  1  din/din_last/din_bytes valid
- din_ready  out  1  padder accepts din this cycle
- din_last  in  1  final word of message
- din_bytes  in  2  valid bytes in last word; 0 means 4. Ignored when din_last=0.
- blk_out  out  1024  assembled block
- blk_valid  out  1  blk_out holds a complete block
- blk_last  out  1  current block is the final block of the message
- blk_ack  in  1  single-cycle pulse: core has loaded blk_out

Behaviour:
- Reset: state=IDLE; din_ready=0, blk_valid=0, blk_last=0, blk_out=0. Word counter and length counter are 0.
- Block geometry:
  - BW (words per block) = 16 for SHA-256, 32 for SHA-512.
  - 32-bit word i of the block (i=0 first).
  - SHA-512: word i maps to blk_out[1023-32i -: 32].
  - SHA-256: word i maps to blk_out[1023-64i -: 64] = {32'h0, word}, i.e. one 32-bit word per 64-bit scheduler lane.
- Length counter: adds 32 per full word and 8*din_bytes on the last word. Counter is modulo 2^LEN_W.
- States:
  - IDLE: din_ready=1. First accepted word latches hash_size and clears the counters. The word is processed as in FILL.
  - FILL: din_ready=1 while wcnt<BW. Each handshake (din_valid & din_ready) writes word wcnt and increments wcnt.
    - wcnt reaching BW without last → OUT (blk_last=0).
    - On din_last with din_bytes=1..3: bytes beyond the valid count are replaced by 0x80 then zeros in the same word. Go to PAD.
    - On din_last with din_bytes=0 (full word): next word written is 0x80000000. Go to PAD.
  - PAD: din_ready=0. Writes zero words until wcnt = BW-LW (LW = 2 for SHA-256, 4 for SHA-512), then → LEN.
    - If the 0x80 byte landed at or after word BW-LW, PAD zero-fills to BW and → OUT with blk_last=0.
    - The next block is then all zero up to the length field (EXTRA flag set).
  - LEN: writes the length, big-endian, into the last LW words, zero-extended. Then → OUT with blk_last=1.
  - OUT: blk_valid=1 and blk_out stable; din_ready=0.
    - On blk_ack: blk_valid=0 next cycle and wcnt=0. Block word storage is cleared to zero.
    - Then → FILL (mid-message), PAD (EXTRA pending), or IDLE (after final block).
- PAD/LEN write one word per cycle. Worst-case latency from final word accepted to blk_valid is BW+1 cycles.
- blk_ack while blk_valid=0 is ignored.
- din_valid while din_ready=0 is held off; no data is lost.
- rst asserted mid-message returns to reset values at once. The partial block is discarded.
- Zero-length messages are not supported. The first word must carry at least one byte.

Optional Feature:
- Macro SHA_PAD_SHA512_EN.
- Defined: hash_size[1] selects 1024-bit blocks as above.
- Not defined: hash_size is ignored and the block is always SHA-256. Word storage is 16x32 only. blk_out is still 1024 bits wide, with lanes formatted {32'h0, word}.

Test Plan:
- SHA-256 "abc": din=0x61626300, din_bytes=3, last.
  → one block with blk_last=1; word0=0x61626380, words1–14=0, word15=0x00000018.
- SHA-512 "abc": same input with hash_size=2'b10.
  → blk_out[1023:960]=0x6162638000000000, blk_out[63:0]=0x18, all other bits 0.
- SHA-256, 56-byte message (14 full words).
  → block 1: data, word14=0x80000000, word15=0, blk_last=0.
  → after blk_ack, block 2: words0–13=0, word15=0x000001C0, blk_last=1.
- SHA-256, 55 bytes (last din_bytes=3).
  → single block, word13 low byte=0x80, word15=0x000001B8.
- Back-pressure: hold blk_ack low for 20 cycles with din_valid=1.
  → din_ready=0 and blk_out stable throughout. After the ack, the next word lands at word0.
- Assert rst for 1 cycle after 5 words.
  → blk_valid=0, din_ready=0 during reset. A new "abc" message then produces the exact "abc" block.
